// File: rtl/ccip_local_mem_responder_if.sv
// CCI-P c0 read / c1 write request and response bundle between an AFU stack and the local-memory responder.
// master = requester side (AFU/MPF), slave = responder side.
interface ccip_local_mem_responder_if;
  logic         c0_req_valid;
  logic [41:0]  c0_req_addr;
  logic [15:0]  c0_req_mdata;
  logic         c1_req_valid;
  logic [41:0]  c1_req_addr;
  logic [15:0]  c1_req_mdata;
  logic [511:0] c1_req_data;
  logic         c0_almost_full;
  logic         c1_almost_full;
  logic         c0_rsp_valid;
  logic [15:0]  c0_rsp_mdata;
  logic [511:0] c0_rsp_data;
  logic         c1_rsp_valid;
  logic [15:0]  c1_rsp_mdata;
  logic         err_overflow;
  logic         err_addr_range;

  modport master (
    output c0_req_valid, c0_req_addr, c0_req_mdata,
    output c1_req_valid, c1_req_addr, c1_req_mdata, c1_req_data,
    input  c0_almost_full, c1_almost_full,
    input  c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
    input  c1_rsp_valid, c1_rsp_mdata,
    input  err_overflow, err_addr_range
  );

  modport slave (
    input  c0_req_valid, c0_req_addr, c0_req_mdata,
    input  c1_req_valid, c1_req_addr, c1_req_mdata, c1_req_data,
    output c0_almost_full, c1_almost_full,
    output c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
    output c1_rsp_valid, c1_rsp_mdata,
    output err_overflow, err_addr_range
  );
endinterface

// File: rtl/ccip_local_mem_responder.sv
// Host-memory stand-in for CCI-P: services c0 reads and c1 writes from a local line store and
// answers each accepted request exactly RSP_LATENCY cycles later, throttling via almost-full.
module ccip_local_mem_responder #(
  parameter int N_LINE_IDX_BITS = 10,
  parameter int RSP_LATENCY     = 4,
  parameter int MAX_OUTSTANDING = 32
) (
  input logic                       clk,
  input logic                       reset,
  ccip_local_mem_responder_if.slave bus
);

  localparam int               CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(MAX_OUTSTANDING - 8);

  logic [511:0]               lineStore [2**N_LINE_IDX_BITS];
  logic [N_LINE_IDX_BITS-1:0] rdIdx;
  logic [N_LINE_IDX_BITS-1:0] wrIdx;
  logic                       c0Accept;
  logic                       c1Accept;
  logic                       addrErr;
  logic                       overflowHit;
  logic [CNT_W-1:0]           c0Count;
  logic [CNT_W-1:0]           c1Count;
  logic [CNT_W-1:0]           c0Inc;
  logic [CNT_W-1:0]           c0Dec;
  logic [CNT_W-1:0]           c1Inc;
  logic [CNT_W-1:0]           c1Dec;
  logic [RSP_LATENCY-1:0]     c0ValidPipe;
  logic [RSP_LATENCY-1:0]     c1ValidPipe;
  logic [15:0]                c0MdataPipe [RSP_LATENCY];
  logic [15:0]                c1MdataPipe [RSP_LATENCY];
  logic [511:0]               rdData;
  logic [511:0]               dataPipe [RSP_LATENCY-1];
  logic                       c0AlmostFull;
  logic                       c1AlmostFull;
  logic                       errOverflow;
  logic                       errAddrRange;

  assign rdIdx = bus.c0_req_addr[N_LINE_IDX_BITS-1:0];
  assign wrIdx = bus.c1_req_addr[N_LINE_IDX_BITS-1:0];

  // A full channel drops the request outright: no store update, no response, no count change.
  assign c0Accept = bus.c0_req_valid && (c0Count != CNT_MAX);
  assign c1Accept = bus.c1_req_valid && (c1Count != CNT_MAX);

  assign overflowHit = (bus.c0_req_valid && (c0Count == CNT_MAX)) ||
                       (bus.c1_req_valid && (c1Count == CNT_MAX));
  assign addrErr = (bus.c0_req_valid && (bus.c0_req_addr[41:N_LINE_IDX_BITS] != '0)) ||
                   (bus.c1_req_valid && (bus.c1_req_addr[41:N_LINE_IDX_BITS] != '0));

  assign c0Inc = {{(CNT_W-1){1'b0}}, c0Accept};
  assign c0Dec = {{(CNT_W-1){1'b0}}, c0ValidPipe[RSP_LATENCY-1]};
  assign c1Inc = {{(CNT_W-1){1'b0}}, c1Accept};
  assign c1Dec = {{(CNT_W-1){1'b0}}, c1ValidPipe[RSP_LATENCY-1]};

  // Read-before-write: a same-cycle read of the line being written sees the old contents.
  always_ff @(posedge clk) begin
    if (c1Accept && !reset) begin
      lineStore[wrIdx] <= bus.c1_req_data;
    end
    rdData      <= lineStore[rdIdx];
    dataPipe[0] <= rdData;
    for (int i = 1; i < RSP_LATENCY - 1; i++) begin
      dataPipe[i] <= dataPipe[i-1];
    end
    c0MdataPipe[0] <= bus.c0_req_mdata;
    c1MdataPipe[0] <= bus.c1_req_mdata;
    for (int i = 1; i < RSP_LATENCY; i++) begin
      c0MdataPipe[i] <= c0MdataPipe[i-1];
      c1MdataPipe[i] <= c1MdataPipe[i-1];
    end
  end

  // Valid pipes, in-flight counters and flags; reset discards anything still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      c0ValidPipe  <= '0;
      c1ValidPipe  <= '0;
      c0Count      <= '0;
      c1Count      <= '0;
      c0AlmostFull <= 1'b0;
      c1AlmostFull <= 1'b0;
      errOverflow  <= 1'b0;
      errAddrRange <= 1'b0;
    end else begin
      c0ValidPipe  <= {c0ValidPipe[RSP_LATENCY-2:0], c0Accept};
      c1ValidPipe  <= {c1ValidPipe[RSP_LATENCY-2:0], c1Accept};
      c0Count      <= c0Count + c0Inc - c0Dec;
      c1Count      <= c1Count + c1Inc - c1Dec;
      c0AlmostFull <= (c0Count >= AF_LEVEL);
      c1AlmostFull <= (c1Count >= AF_LEVEL);
      errOverflow  <= errOverflow | overflowHit;
      errAddrRange <= errAddrRange | addrErr;
    end
  end

  assign bus.c0_rsp_valid   = c0ValidPipe[RSP_LATENCY-1];
  assign bus.c0_rsp_mdata   = c0MdataPipe[RSP_LATENCY-1];
  assign bus.c0_rsp_data    = dataPipe[RSP_LATENCY-2];
  assign bus.c1_rsp_valid   = c1ValidPipe[RSP_LATENCY-1];
  assign bus.c1_rsp_mdata   = c1MdataPipe[RSP_LATENCY-1];
  assign bus.c0_almost_full = c0AlmostFull;
  assign bus.c1_almost_full = c1AlmostFull;
  assign bus.err_overflow   = errOverflow;
  assign bus.err_addr_range = errAddrRange;

endmodule
